exe_stage: RTL and testbench
============================

EXE_STAGE -- requirements
Module: exe_stage

Interface
REQ-001 Parameter PAYLOAD_WD, default 64: width of the opaque ID-to-MEM payload carried unchanged through the stage.
REQ-002 Reset is asynchronous and active-high; one clock; clk and reset are named as below.
REQ-003 clk  in  1  stage clock; all state updates on posedge.
REQ-004 reset  in  1  asynchronous active-high reset.
REQ-005 id_to_exe_valid  in  1  ID holds a valid instruction; exe_allowin  out  1  EXE can accept one this cycle.
REQ-006 id_payload  in  PAYLOAD_WD  opaque fields; id_pc  in  32  instruction PC; id_excp  in  1  upstream exception already flagged.
REQ-007 id_mem_we  in  1  store; id_mem_re  in  1  load; id_mem_size  in  2  01 byte, 10 half, 11 word.
REQ-008 id_addr_base, id_addr_offs  in  32 each  address operands; id_store_data  in  32  store source.
REQ-009 mem_allowin  in  1; exe_to_mem_valid  out  1; exe_to_mem_bus  out  PAYLOAD_WD+71  {payload, pc, mem_we, mem_re, size, addr, excp_out, ale}.
REQ-010 flush  in  1  MEM exception/ertn/refetch flush.
REQ-011 data_sram_req  out  1; data_sram_wr  out  1; data_sram_size  out  2; data_sram_wstrb  out  4; data_sram_addr  out  32; data_sram_wdata  out  32.
REQ-012 data_sram_addr_ok  in  1; data_sram_data_ok  in  1; mem_data_ok  out  1  filtered data_ok for MEM.

Function
REQ-013 Pipeline register exe_valid; exe_allowin = ~exe_valid | (exe_ready_go & mem_allowin); exe_to_mem_valid = exe_valid & exe_ready_go.
REQ-014 On a cycle with flush=1, exe_valid clears next cycle regardless of id_to_exe_valid; otherwise, when exe_allowin=1, exe_valid loads id_to_exe_valid.
REQ-015 The data register loads all id_* inputs only when exe_allowin & id_to_exe_valid; it holds otherwise.
REQ-016 addr = id_addr_base + id_addr_offs, computed at ID input and registered, modulo 2^32.
REQ-017 ale = (we|re) & ((size==10 & addr[0]) | (size==11 & addr[1:0]!=0)); excp_out = excp | ale.
REQ-018 need_req = exe_valid & (we|re) & ~excp_out.
REQ-019 data_sram_req = need_req & mem_allowin & ~flush & (cancel_cnt==0) & (out_cnt<2).
REQ-020 exe_ready_go = ~need_req | (data_sram_req & data_sram_addr_ok); requests are single-cycle accepted; there is no issued-but-not-forwarded state.
REQ-021 data_sram_wr = we; data_sram_size = size-1 (0 byte, 1 half, 2 word); data_sram_addr = addr.
REQ-022 wstrb: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111; 0000 when wr=0.
REQ-023 wdata: byte {4{data[7:0]}}; half {2{data[15:0]}}; word data.
REQ-024 out_cnt, 2 bits, 0..2: +1 on req&addr_ok, -1 on data_ok; both in one cycle leaves it unchanged.
REQ-025 cancel_cnt, 2 bits: on a flush cycle it loads out_cnt, plus 1 if req&addr_ok, minus 1 if data_ok; otherwise it decrements on each data_ok while nonzero.
REQ-026 mem_data_ok = data_sram_data_ok & (cancel_cnt==0); stale responses are swallowed.
REQ-027 data_ok with out_cnt==0 is a protocol error; counters saturate at 0 and never wrap.

Reset
REQ-028 While reset is high, exe_valid, out_cnt and cancel_cnt are 0.
REQ-029 While reset is high, data_sram_req, exe_to_mem_valid and mem_data_ok are 0, and exe_allowin is 1.
REQ-030 Reset during an outstanding request discards all tracking, and the first post-reset data_ok passes through.

Verification
REQ-031 Word load base=0x1000 offs=0x4, addr_ok same cycle -> req=1, addr=0x1004, size=2, wstrb=0, exe_to_mem_valid=1 that cycle.
REQ-032 Byte store addr=0x...3 data=0x000000AB -> wstrb=1000, wdata=0xABABABAB; half store addr=0x2 -> wstrb=1100.
REQ-033 Word load addr=0x1002 -> ale=1, excp_out=1, req never asserted, forwarded in 1 cycle.
REQ-034 addr_ok held 0 for 3 cycles -> req stays 1 with stable addr/wdata, exe_allowin=0, advances on the 4th cycle.
REQ-035 Two loads accepted, flush before any data_ok -> cancel_cnt=2; next two data_ok give mem_data_ok=0, the third gives 1.
REQ-036 Flush with exe_valid=1 and mem_allowin=0 -> exe_valid=0 next cycle and no req issued.

Source files
------------

// File: rtl/exe_stage.sv
// exe_stage: address generation and data SRAM request issue, with
// outstanding-response tracking so responses of flushed requests are dropped.
module exe_stage #(
  parameter int PAYLOAD_WD = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    id_to_exe_valid,
  output logic                    exe_allowin,
  input  logic [PAYLOAD_WD-1:0]   id_payload,
  input  logic [31:0]             id_pc,
  input  logic                    id_excp,
  input  logic                    id_mem_we,
  input  logic                    id_mem_re,
  input  logic [1:0]              id_mem_size,
  input  logic [31:0]             id_addr_base,
  input  logic [31:0]             id_addr_offs,
  input  logic [31:0]             id_store_data,
  input  logic                    mem_allowin,
  output logic                    exe_to_mem_valid,
  output logic [PAYLOAD_WD+70:0]  exe_to_mem_bus,
  input  logic                    flush,
  output logic                    data_sram_req,
  output logic                    data_sram_wr,
  output logic [1:0]              data_sram_size,
  output logic [3:0]              data_sram_wstrb,
  output logic [31:0]             data_sram_addr,
  output logic [31:0]             data_sram_wdata,
  input  logic                    data_sram_addr_ok,
  input  logic                    data_sram_data_ok,
  output logic                    mem_data_ok
);

  logic                  exe_valid_q, exe_valid_d;
  logic [PAYLOAD_WD-1:0] payload_q;
  logic [31:0]           pc_q, addr_q, sdata_q;
  logic                  excp_q, we_q, re_q;
  logic [1:0]            size_q;
  logic [1:0]            out_cnt_q, out_cnt_d;
  logic [1:0]            cancel_cnt_q, cancel_cnt_d;

  logic is_mem, ale, excp_out, need_req, ready_go;
  logic load_en, acc, rsp;

  always_comb begin
    is_mem   = we_q | re_q;
    ale      = is_mem & ((size_q == 2'b10 & addr_q[0]) |
                         (size_q == 2'b11 & (addr_q[1:0] != 2'b00)));
    excp_out = excp_q | ale;
    need_req = exe_valid_q & is_mem & ~excp_out;
    data_sram_req = need_req & mem_allowin & ~flush &
                    (cancel_cnt_q == 2'd0) & (out_cnt_q < 2'd2);
    ready_go = ~need_req | (data_sram_req & data_sram_addr_ok);
    exe_allowin      = ~exe_valid_q | (ready_go & mem_allowin);
    exe_to_mem_valid = exe_valid_q & ready_go;
    load_en = exe_allowin & id_to_exe_valid;
    acc = data_sram_req & data_sram_addr_ok;
    rsp = data_sram_data_ok & (out_cnt_q != 2'd0);
    mem_data_ok = data_sram_data_ok & (cancel_cnt_q == 2'd0) & ~reset;
  end

  always_comb begin
    exe_valid_d = exe_valid_q;
    if (flush)            exe_valid_d = 1'b0;
    else if (exe_allowin) exe_valid_d = id_to_exe_valid;
  end

  always_comb begin
    out_cnt_d = out_cnt_q;
    if (acc & ~rsp & (out_cnt_q != 2'd2)) out_cnt_d = out_cnt_q + 2'd1;
    else if (~acc & rsp)                  out_cnt_d = out_cnt_q - 2'd1;
  end

  // On flush every request still in flight becomes stale.
  always_comb begin
    cancel_cnt_d = cancel_cnt_q;
    if (flush) cancel_cnt_d = out_cnt_d;
    else if (data_sram_data_ok & (cancel_cnt_q != 2'd0))
      cancel_cnt_d = cancel_cnt_q - 2'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exe_valid_q  <= 1'b0;
      out_cnt_q    <= 2'd0;
      cancel_cnt_q <= 2'd0;
    end else begin
      exe_valid_q  <= exe_valid_d;
      out_cnt_q    <= out_cnt_d;
      cancel_cnt_q <= cancel_cnt_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      payload_q <= '0;
      pc_q      <= '0;
      excp_q    <= 1'b0;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      size_q    <= 2'b00;
      addr_q    <= '0;
      sdata_q   <= '0;
    end else if (load_en) begin
      payload_q <= id_payload;
      pc_q      <= id_pc;
      excp_q    <= id_excp;
      we_q      <= id_mem_we;
      re_q      <= id_mem_re;
      size_q    <= id_mem_size;
      addr_q    <= id_addr_base + id_addr_offs;
      sdata_q   <= id_store_data;
    end
  end

  always_comb begin
    data_sram_wstrb = 4'b0000;
    data_sram_wdata = sdata_q;
    unique case (size_q)
      2'b01: begin
        data_sram_wstrb = 4'b0001 << addr_q[1:0];
        data_sram_wdata = {4{sdata_q[7:0]}};
      end
      2'b10: begin
        data_sram_wstrb = 4'b0011 << addr_q[1:0];
        data_sram_wdata = {2{sdata_q[15:0]}};
      end
      2'b11: data_sram_wstrb = 4'b1111;
      default: data_sram_wstrb = 4'b0000;
    endcase
    if (!we_q) data_sram_wstrb = 4'b0000;
  end

  assign data_sram_wr   = we_q;
  assign data_sram_size = size_q - 2'd1;
  assign data_sram_addr = addr_q;

  // Spare MSB tied low; remaining fields in MEM's expected order.
  assign exe_to_mem_bus = {1'b0, payload_q, pc_q, we_q, re_q, size_q,
                           addr_q, excp_out, ale};

endmodule

// File: tb/tb_exe_stage.sv
// tb_exe_stage: scenario tasks drive exe_stage; forwarded bus values are
// checked against a queue of expectations pushed when each op is sent.
module tb_exe_stage;
  localparam int PW = 64;

  logic clk = 1'b0;
  logic reset;
  logic id_to_exe_valid, exe_allowin;
  logic [PW-1:0] id_payload;
  logic [31:0] id_pc, id_addr_base, id_addr_offs, id_store_data;
  logic id_excp, id_mem_we, id_mem_re;
  logic [1:0] id_mem_size;
  logic mem_allowin, exe_to_mem_valid, flush;
  logic [PW+70:0] exe_to_mem_bus;
  logic data_sram_req, data_sram_wr;
  logic [1:0] data_sram_size;
  logic [3:0] data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic data_sram_addr_ok, data_sram_data_ok, mem_data_ok;

  int checks = 0;
  int failures = 0;
  logic [PW+70:0] sb[$];
  logic [PW+70:0] exp_bus;

  exe_stage #(.PAYLOAD_WD(PW)) dut (
    .clk(clk), .reset(reset),
    .id_to_exe_valid(id_to_exe_valid), .exe_allowin(exe_allowin),
    .id_payload(id_payload), .id_pc(id_pc), .id_excp(id_excp),
    .id_mem_we(id_mem_we), .id_mem_re(id_mem_re),
    .id_mem_size(id_mem_size),
    .id_addr_base(id_addr_base), .id_addr_offs(id_addr_offs),
    .id_store_data(id_store_data),
    .mem_allowin(mem_allowin), .exe_to_mem_valid(exe_to_mem_valid),
    .exe_to_mem_bus(exe_to_mem_bus), .flush(flush),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok),
    .data_sram_data_ok(data_sram_data_ok), .mem_data_ok(mem_data_ok)
  );

  always #5 clk = ~clk;

  // Presents one op to ID for a cycle; returns #1 after it enters EXE.
  task automatic send(input logic we, input logic re,
                      input logic [1:0] sz, input logic [31:0] b,
                      input logic [31:0] o, input logic [31:0] d,
                      input logic ex, input bit keep);
    logic [31:0] a;
    logic al;
    @(posedge clk); #1;
    id_to_exe_valid = 1'b1;
    id_mem_we = we; id_mem_re = re; id_mem_size = sz;
    id_addr_base = b; id_addr_offs = o; id_store_data = d;
    id_excp = ex;
    id_payload = {$urandom(), $urandom()};
    id_pc = $urandom();
    a = b + o;
    al = (we | re) && ((sz == 2'b10 && a[0]) ||
                       (sz == 2'b11 && a[1:0] != 2'b00));
    if (keep)
      sb.push_back({1'b0, id_payload, id_pc, we, re, sz, a, ex | al, al});
    @(posedge clk); #1;
    id_to_exe_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    id_to_exe_valid = 1'b1; id_mem_re = 1'b1; id_mem_size = 2'b11;
    data_sram_data_ok = 1'b1;
    @(negedge clk);
    checks++;
    if (exe_allowin !== 1'b1) begin
      failures++; $display("FAIL rst_allowin got=%b exp=1", exe_allowin);
    end
    checks++;
    if ({data_sram_req, exe_to_mem_valid, mem_data_ok} !== 3'b000) begin
      failures++;
      $display("FAIL rst_outs got=%b%b%b exp=000",
               data_sram_req, exe_to_mem_valid, mem_data_ok);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    id_to_exe_valid = 1'b0; id_mem_re = 1'b0; id_mem_size = 2'b00;
    data_sram_data_ok = 1'b0;
  endtask

  task automatic test_word_load();
    send(1'b0, 1'b1, 2'b11, 32'h1000, 32'h4, 32'h0, 1'b0, 1'b1);
    data_sram_addr_ok = 1'b1;
    @(negedge clk);
    checks++;
    if ({data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb}
        !== {1'b1, 1'b0, 2'd2, 4'b0000}) begin
      failures++;
      $display("FAIL ld_ctl got req=%b wr=%b sz=%0d strb=%b exp 1 0 2 0000",
               data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb);
    end
    checks++;
    if (data_sram_addr !== 32'h1004) begin
      failures++; $display("FAIL ld_addr got=%h exp=00001004", data_sram_addr);
    end
    checks++;
    if (exe_to_mem_valid !== 1'b1 || sb.size() == 0) begin
      failures++; $display("FAIL ld_fwd got=%b exp=1", exe_to_mem_valid);
    end else begin
      exp_bus = sb.pop_front();
      checks++;
      if (exe_to_mem_bus !== exp_bus) begin
        failures++;
        $display("FAIL ld_bus got=%h exp=%h", exe_to_mem_bus, exp_bus);
      end
    end
    @(posedge clk); #1;
    data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_data_ok !== 1'b1) begin
      failures++; $display("FAIL ld_rsp got=%b exp=1", mem_data_ok);
    end
    @(posedge clk); #1;
    data_sram_data_ok = 1'b0;
  endtask

  task automatic test_stores();
    logic [31:0] wd[2];
    logic [3:0]  ws[2];
    wd[0] = 32'hABABABAB; ws[0] = 4'b1000;
    wd[1] = 32'h12341234; ws[1] = 4'b1100;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) send(1'b1, 1'b0, 2'b01, 32'h100, 32'h3, 32'hAB,
                       1'b0, 1'b1);
      else        send(1'b1, 1'b0, 2'b10, 32'h0, 32'h2, 32'h5555_1234,
                       1'b0, 1'b1);
      data_sram_addr_ok = 1'b1;
      @(negedge clk);
      checks++;
      if (data_sram_wstrb !== ws[i] || data_sram_wdata !== wd[i]) begin
        failures++;
        $display("FAIL st%0d got strb=%b wdata=%h exp strb=%b wdata=%h",
                 i, data_sram_wstrb, data_sram_wdata, ws[i], wd[i]);
      end
      checks++;
      if (data_sram_wr !== 1'b1 || data_sram_size !== 2'(i)) begin
        failures++;
        $display("FAIL st%0d_ctl got wr=%b sz=%0d exp wr=1 sz=%0d",
                 i, data_sram_wr, data_sram_size, i);
      end
      checks++;
      if (exe_to_mem_valid !== 1'b1 || sb.size() == 0) begin
        failures++; $display("FAIL st%0d_fwd got=%b exp=1", i,
                             exe_to_mem_valid);
      end else begin
        exp_bus = sb.pop_front();
        checks++;
        if (exe_to_mem_bus !== exp_bus) begin
          failures++;
          $display("FAIL st%0d_bus got=%h exp=%h", i, exe_to_mem_bus,
                   exp_bus);
        end
      end
      @(posedge clk); #1;
      data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b1;
      @(posedge clk); #1;
      data_sram_data_ok = 1'b0;
    end
  endtask

  task automatic test_exceptions();
    for (int i = 0; i < 2; i++) begin
      if (i == 0) send(1'b0, 1'b1, 2'b11, 32'h1000, 32'h2, 32'h0,
                       1'b0, 1'b1);
      else        send(1'b0, 1'b1, 2'b11, 32'h2000, 32'h0, 32'h0,
                       1'b1, 1'b1);
      @(negedge clk);
      checks++;
      if (data_sram_req !== 1'b0) begin
        failures++; $display("FAIL exc%0d_req got=%b exp=0", i,
                             data_sram_req);
      end
      checks++;
      if (exe_to_mem_valid !== 1'b1 || sb.size() == 0) begin
        failures++; $display("FAIL exc%0d_fwd got=%b exp=1", i,
                             exe_to_mem_valid);
      end else begin
        exp_bus = sb.pop_front();
        checks++;
        if (exe_to_mem_bus !== exp_bus) begin
          failures++;
          $display("FAIL exc%0d_bus got=%h exp=%h", i, exe_to_mem_bus,
                   exp_bus);
        end
      end
    end
  endtask

  task automatic test_stall();
    send(1'b1, 1'b0, 2'b11, 32'h2000, 32'h10, 32'hDEADBEEF, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({data_sram_req, exe_allowin, exe_to_mem_valid} !== 3'b100 ||
          data_sram_addr !== 32'h2010 ||
          data_sram_wdata !== 32'hDEADBEEF) begin
        failures++;
        $display("FAIL stall%0d got req=%b allow=%b fwd=%b a=%h d=%h",
                 i, data_sram_req, exe_allowin, exe_to_mem_valid,
                 data_sram_addr, data_sram_wdata);
      end
      @(posedge clk); #1;
    end
    data_sram_addr_ok = 1'b1;
    @(negedge clk);
    checks++;
    if (exe_to_mem_valid !== 1'b1 || sb.size() == 0) begin
      failures++; $display("FAIL stall_fwd got=%b exp=1", exe_to_mem_valid);
    end else begin
      exp_bus = sb.pop_front();
      checks++;
      if (exe_to_mem_bus !== exp_bus) begin
        failures++;
        $display("FAIL stall_bus got=%h exp=%h", exe_to_mem_bus, exp_bus);
      end
    end
    @(posedge clk); #1;
    data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b1;
    @(posedge clk); #1;
    data_sram_data_ok = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 2; i++) begin
      send(1'b0, 1'b1, 2'b11, 32'h3000, 32'(i * 4), 32'h0, 1'b0, 1'b1);
      data_sram_addr_ok = 1'b1;
      @(negedge clk);
      checks++;
      if (exe_to_mem_valid !== 1'b1 || sb.size() == 0) begin
        failures++; $display("FAIL b2b%0d_fwd got=%b exp=1", i,
                             exe_to_mem_valid);
      end else begin
        exp_bus = sb.pop_front();
        checks++;
        if (exe_to_mem_bus !== exp_bus) begin
          failures++;
          $display("FAIL b2b%0d_bus got=%h exp=%h", i, exe_to_mem_bus,
                   exp_bus);
        end
      end
      @(posedge clk); #1;
      data_sram_addr_ok = 1'b0;
    end
    send(1'b0, 1'b1, 2'b11, 32'h3000, 32'h8, 32'h0, 1'b0, 1'b1);
    data_sram_addr_ok = 1'b1; data_sram_data_ok = 1'b1;
    @(negedge clk);
    checks++;
    if ({data_sram_req, exe_allowin, mem_data_ok} !== 3'b001) begin
      failures++;
      $display("FAIL b2b_limit got req=%b allow=%b dok=%b exp 0 0 1",
               data_sram_req, exe_allowin, mem_data_ok);
    end
    @(posedge clk); #1;
    data_sram_data_ok = 1'b0;
    @(negedge clk);
    checks++;
    if (exe_to_mem_valid !== 1'b1 || sb.size() == 0) begin
      failures++; $display("FAIL b2b2_fwd got=%b exp=1", exe_to_mem_valid);
    end else begin
      exp_bus = sb.pop_front();
      checks++;
      if (exe_to_mem_bus !== exp_bus) begin
        failures++;
        $display("FAIL b2b2_bus got=%h exp=%h", exe_to_mem_bus, exp_bus);
      end
    end
    @(posedge clk); #1;
    data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    data_sram_data_ok = 1'b0;
  endtask

  task automatic test_flush_cancel();
    for (int i = 0; i < 2; i++) begin
      send(1'b0, 1'b1, 2'b11, 32'h4000, 32'(i * 4), 32'h0, 1'b0, 1'b1);
      data_sram_addr_ok = 1'b1;
      @(negedge clk);
      checks++;
      if (exe_to_mem_valid !== 1'b1 || sb.size() == 0) begin
        failures++; $display("FAIL fc%0d_fwd got=%b exp=1", i,
                             exe_to_mem_valid);
      end else begin
        exp_bus = sb.pop_front();
        checks++;
        if (exe_to_mem_bus !== exp_bus) begin
          failures++;
          $display("FAIL fc%0d_bus got=%h exp=%h", i, exe_to_mem_bus,
                   exp_bus);
        end
      end
      @(posedge clk); #1;
      data_sram_addr_ok = 1'b0;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; data_sram_data_ok = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (mem_data_ok !== 1'b0) begin
        failures++; $display("FAIL fc_stale%0d got=%b exp=0", i,
                             mem_data_ok);
      end
      @(posedge clk); #1;
    end
    data_sram_data_ok = 1'b0;
    send(1'b0, 1'b1, 2'b11, 32'h4000, 32'h8, 32'h0, 1'b0, 1'b1);
    data_sram_addr_ok = 1'b1;
    @(negedge clk);
    checks++;
    if (data_sram_req !== 1'b1) begin
      failures++; $display("FAIL fc_req got=%b exp=1", data_sram_req);
    end
    if (exe_to_mem_valid === 1'b1 && sb.size() != 0) exp_bus = sb.pop_front();
    @(posedge clk); #1;
    data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_data_ok !== 1'b1) begin
      failures++; $display("FAIL fc_live got=%b exp=1", mem_data_ok);
    end
    @(posedge clk); #1;
    data_sram_data_ok = 1'b0;
  endtask

  task automatic test_flush_kill();
    mem_allowin = 1'b0;
    send(1'b0, 1'b1, 2'b11, 32'h5000, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if ({data_sram_req, exe_to_mem_valid, exe_allowin} !== 3'b000) begin
      failures++;
      $display("FAIL fk_hold got req=%b fwd=%b allow=%b exp 000",
               data_sram_req, exe_to_mem_valid, exe_allowin);
    end
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    checks++;
    if (data_sram_req !== 1'b0) begin
      failures++; $display("FAIL fk_req got=%b exp=0", data_sram_req);
    end
    @(posedge clk); #1;
    flush = 1'b0; mem_allowin = 1'b1;
    @(negedge clk);
    checks++;
    if ({data_sram_req, exe_to_mem_valid, exe_allowin} !== 3'b001) begin
      failures++;
      $display("FAIL fk_gone got req=%b fwd=%b allow=%b exp 001",
               data_sram_req, exe_to_mem_valid, exe_allowin);
    end
  endtask

  task automatic test_reset_outstanding();
    send(1'b0, 1'b1, 2'b11, 32'h6000, 32'h0, 32'h0, 1'b0, 1'b0);
    data_sram_addr_ok = 1'b1;
    @(posedge clk); #1;
    data_sram_addr_ok = 1'b0; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; data_sram_data_ok = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_data_ok !== 1'b1) begin
      failures++; $display("FAIL rst_track got=%b exp=1", mem_data_ok);
    end
    @(posedge clk); #1;
    data_sram_data_ok = 1'b0;
  endtask

  initial begin
    id_to_exe_valid = 1'b0; id_payload = '0; id_pc = '0; id_excp = 1'b0;
    id_mem_we = 1'b0; id_mem_re = 1'b0; id_mem_size = 2'b00;
    id_addr_base = '0; id_addr_offs = '0; id_store_data = '0;
    mem_allowin = 1'b1; flush = 1'b0;
    data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0;
    test_reset();
    test_word_load();
    test_stores();
    test_exceptions();
    test_stall();
    test_back_to_back();
    test_flush_cancel();
    test_flush_kill();
    test_reset_outstanding();
    checks++;
    if (sb.size() != 0) begin
      failures++; $display("FAIL sb_drain got=%0d exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
